// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the chunk-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a counter over n chunks; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_chunk.sv
// Combinational CHUNK-bit subtract slice: o_diff = i_a - i_b - i_borrow, with borrow-out.
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_borrow,
  output logic [CHUNK-1:0] o_diff,
  output logic             o_borrow
);

  logic [CHUNK:0] w_full;

  // One guard bit above the slice catches the borrow as a wrap to all-ones.
  assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_borrow};
  assign o_diff   = w_full[CHUNK-1:0];
  assign o_borrow = w_full[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: x - y - bin computed CHUNK bits per cycle through one sub_chunk slice.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNK  = DEF_CHUNK,
  parameter int DWIDTH = WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bin,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] diff,
  output logic              bout,
  output logic              diff_zero
);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("serial_subtractor: CHUNK must be >= 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_res;
  logic [IDX_W-1:0]   r_idx;
  logic               r_borrow;
  logic [DWIDTH-1:0]  r_diff;
  logic               r_bout;
  logic               r_zero;
  logic               r_out_valid;
  logic               r_in_ready;

  logic [CHUNK-1:0]       w_slice;
  logic                   w_borrow;
  logic [WIDTH+CHUNK-1:0] w_shift;
  logic [DWIDTH-1:0]      w_final;

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .i_a      (r_x[CHUNK-1:0]),
    .i_b      (r_y[CHUNK-1:0]),
    .i_borrow (r_borrow),
    .o_diff   (w_slice),
    .o_borrow (w_borrow)
  );

  // Operands shift down so the active chunk is always at bit 0; results shift in from the top.
  assign w_shift = {w_slice, r_res} >> CHUNK;
  assign w_final = DWIDTH'({w_borrow, w_shift[WIDTH-1:0]});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_borrow    <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x        <= x;
            r_y        <= y;
            r_borrow   <= bin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_x      <= r_x >> CHUNK;
          r_y      <= r_y >> CHUNK;
          r_res    <= w_shift[WIDTH-1:0];
          r_borrow <= w_borrow;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_diff      <= w_final;
            r_bout      <= w_borrow;
            r_zero      <= (w_final == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign diff_zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at default WIDTH=32, CHUNK=8.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        bin = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] diff;
  logic        bout;
  logic        diff_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .diff_zero (diff_zero)
  );

  // Directed vectors: x, y, bin and hand-computed 33-bit result.
  logic [31:0] vx   [7] = '{32'd5, 32'd0, 32'h12345678, 32'h12345678, 32'h00000100, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] vy   [7] = '{32'd3, 32'd1, 32'h12345678, 32'h12345678, 32'h00000001, 32'h7FFFFFFF, 32'h00000000};
  logic        vb   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [32:0] vd   [7] = '{33'h0_00000002, 33'h1_FFFFFFFF, 33'h0_00000000, 33'h1_FFFFFFFF,
                            33'h0_000000FF, 33'h0_00000001, 33'h0_FFFFFFFE};

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
    x = a; y = b; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (diff !== 33'h0 || bout !== 1'b0 || diff_zero !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got diff=%h bout=%b zero=%b want 0/0/0", diff, bout, diff_zero);
    end
  endtask

  task automatic test_arith();
    int lat;
    logic [32:0] exp_d;
    for (int i = 0; i < 7; i++) begin
      exp_d = vd[i];
      start_op(vx[i], vy[i], vb[i]);
      // Operand changes after the accepting edge must not leak into the result.
      x = ~vx[i]; y = ~vy[i]; bin = ~vb[i];
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL arith%0d_busy_ready got %b want 0", i, in_ready); end
      wait_done(lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL arith%0d_latency got %0d want 4", i, lat); end
      checks++;
      if (diff !== exp_d) begin errors++; $display("FAIL arith%0d_diff got %h want %h", i, diff, exp_d); end
      checks++;
      if (bout !== exp_d[32]) begin errors++; $display("FAIL arith%0d_bout got %b want %b", i, bout, exp_d[32]); end
      checks++;
      if (diff_zero !== (exp_d == 33'h0)) begin
        errors++; $display("FAIL arith%0d_zero got %b want %b", i, diff_zero, (exp_d == 33'h0));
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL arith%0d_done_ready got %b want 0", i, in_ready); end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL arith%0d_consume got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    start_op(32'd100, 32'd1, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL hold_latency got %0d want 4", lat); end
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      x = $urandom; y = $urandom; bin = c[0];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold%0d_handshake got valid=%b ready=%b want 1/0", c, out_valid, in_ready);
      end
      checks++;
      if (diff !== 33'd99 || bout !== 1'b0 || diff_zero !== 1'b0) begin
        errors++; $display("FAIL hold%0d_data got diff=%h bout=%b zero=%b want 063/0/0", c, diff, bout, diff_zero);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_consume got %b want 0", out_valid); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL hold_single_result got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    start_op(32'd7, 32'd2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 33'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state got valid=%b diff=%h ready=%b want 0/0/1", out_valid, diff, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_pulse%0d got %b want 0", c, out_valid); end
    end
    start_op(32'd9, 32'd4, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL abort_next_latency got %0d want 4", lat); end
    checks++;
    if (diff !== 33'd5 || bout !== 1'b0 || diff_zero !== 1'b0) begin
      errors++; $display("FAIL abort_next_diff got diff=%h bout=%b zero=%b want 005/0/0", diff, bout, diff_zero);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_hold();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
